password_sender: RTL and testbench
==================================

PASSWORD_SENDER -- requirements
Module: password_sender

Interface
REQ-001 Parameter HOLD, default 2: cycles each enable strobe stays high per digit.
REQ-002 Parameter GAP, default 2: cycles with enable low between consecutive digits.
REQ-003 Parameter TIMEOUT, default 16: cycles to wait for admitted after the last digit.
REQ-004 Parameter COOL, default 16: cycles enable stays idle before a retry.
REQ-005 Parameter RETRIES, default 3: total attempts allowed, range 1..4.
REQ-006 Port: clock  input  1  system clock, rising-edge active.
REQ-007 Port: rst  input  1  reset, asynchronous, active-low.
REQ-008 Port: start  input  1  request to send the code; sampled in IDLE only.
REQ-009 Port: code  input  16  four BCD digits; digit0 = code[3:0] is sent first, digit3 = code[15:12] is sent last.
REQ-010 Port: admitted  input  1  lock acknowledge.
REQ-011 Port: enable  output  4  one-hot digit strobe; bit i marks digit i.
REQ-012 Port: enteredPassword  output  4  digit value presented to the lock.
REQ-013 Port: busy  output  1  high in every state except IDLE.
REQ-014 Port: done  output  1  one-cycle pulse on success.
REQ-015 Port: fail  output  1  one-cycle pulse when all attempts are exhausted.
REQ-016 Port: attempt  output  2  zero-based index of the current attempt.

Function
REQ-017 States: IDLE, DRIVE, GAP, WAIT, COOL, DONE, FAIL; all outputs registered.
REQ-018 IDLE with start=1 at edge k: latch code into an internal register, set idx=0 and attempt=0, and enter DRIVE so that enable[0]=1 is visible after edge k.
REQ-019 DRIVE: enteredPassword = digit[idx] and enable = 1<<idx for exactly HOLD cycles, then go to GAP.
REQ-020 GAP: enable=0 and enteredPassword holds digit[idx] for exactly GAP cycles; then, if idx<3, increment idx and go to DRIVE, else go to WAIT.
REQ-021 The full drive phase lasts 4*(HOLD+GAP) cycles; enable is never multi-hot.
REQ-022 WAIT: enable=0 and enteredPassword=0; admitted=1 goes to DONE; TIMEOUT cycles elapsing without admitted is a timeout.
REQ-023 If admitted=1 arrives in the same cycle as timeout expiry, admitted wins and the block goes to DONE.
REQ-024 On timeout with attempt<RETRIES-1: increment attempt and go to COOL; otherwise go to FAIL.
REQ-025 COOL: all strobes low for COOL cycles, then set idx=0 and go to DRIVE.
REQ-026 DONE and FAIL each last one cycle, assert done or fail respectively, then return to IDLE.
REQ-027 start is ignored while busy=1, and the latched code does not change mid-sequence.
REQ-028 admitted is ignored outside WAIT.
REQ-029 A single phase counter, sized $clog2 of the maximum of the timing parameters plus 1, is reloaded on every state entry.

Reset
REQ-030 While rst=0: state=IDLE, and idx, attempt, the counter, the code register and every output are 0, independent of clock.
REQ-031 Reset asserted mid-sequence aborts the sequence immediately; after release the block stays in IDLE until a new start.

Structure
REQ-032 Package password_pkg holds the state enum, DIGIT_W=4 and NUM_DIGITS=4.
REQ-033 One sub-module, sender_timer, is used: a loadable down-counter with a zero flag.

Verification (HOLD=2, GAP=2, TIMEOUT=16, COOL=16, RETRIES=3)
REQ-034 code=16'h4321, start pulse, admitted raised 3 cycles into WAIT -> the bench sees 1,2,3,4 with enable 0001,0010,0100,1000 each high for 2 cycles, then done=1 for one cycle.
REQ-035 code=16'h4321, admitted held at 0 -> three attempts (attempt=0,1,2) separated by 16-cycle COOL phases, then fail=1 and busy=0.
REQ-036 First attempt times out and admitted is raised in the second WAIT -> done=1 with attempt=1.
REQ-037 admitted=1 on the final WAIT cycle -> done, not a retry; start pulsed mid-DRIVE with code=16'h9999 -> ignored, and digits still follow 16'h4321.
REQ-038 rst=0 during GAP of digit 2 -> enable=0, busy=0, attempt=0 immediately; after release there is no activity until start.

Source files
------------

// File: rtl/password_pkg.sv
// password_pkg: shared state encoding, digit geometry and digit selection for the password sender.
package password_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;

    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_GAP, S_WAIT, S_COOL, S_DONE, S_FAIL} state_t;

    function automatic logic [DIGIT_W-1:0] digit(input logic [NUM_DIGITS*DIGIT_W-1:0] c, input logic [1:0] i);
        return c[i*DIGIT_W +: DIGIT_W];
    endfunction

endpackage

// File: rtl/sender_timer.sv
// sender_timer: loadable down-counter that parks at zero and flags it.
module sender_timer #(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge rst)
        if (!rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;

    assign zero = count == '0;

endmodule

// File: rtl/password_sender.sv
// password_sender: strobes a four-digit BCD code into a lock, waits for admission and retries on timeout.
module password_sender
    import password_pkg::*;
#(
    parameter int HOLD    = 2,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 16,
    parameter int COOL    = 16,
    parameter int RETRIES = 3
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] code,
    input  logic                          admitted,
    output logic [NUM_DIGITS-1:0]         enable,
    output logic [DIGIT_W-1:0]            enteredPassword,
    output logic                          busy,
    output logic                          done,
    output logic                          fail,
    output logic [1:0]                    attempt
);

    localparam int M1    = HOLD > GAP ? HOLD : GAP;
    localparam int M2    = TIMEOUT > COOL ? TIMEOUT : COOL;
    localparam int MAX_T = M1 > M2 ? M1 : M2;
    localparam int CW    = $clog2(MAX_T + 1);

    state_t                        state, nxt;
    logic [NUM_DIGITS*DIGIT_W-1:0] code_q, code_n;
    logic [1:0]                    idx, idx_n, attempt_n;
    logic                          zero, load, retry;
    logic [CW-1:0]                 load_val;

    assign retry = int'(attempt) < RETRIES - 1;

    always_comb begin
        nxt       = state;
        idx_n     = idx;
        attempt_n = attempt;
        code_n    = code_q;
        case (state)
            S_IDLE: if (start) begin
                nxt       = S_DRIVE;
                idx_n     = '0;
                attempt_n = '0;
                code_n    = code;
            end
            S_DRIVE: if (zero) nxt = S_GAP;
            S_GAP: if (zero) begin
                nxt   = idx == 2'd3 ? S_WAIT : S_DRIVE;
                idx_n = idx == 2'd3 ? idx : idx + 2'd1;
            end
            // admission is checked before expiry so a last-cycle acknowledge still succeeds
            S_WAIT: if (admitted) nxt = S_DONE;
                    else if (zero) begin
                        nxt       = retry ? S_COOL : S_FAIL;
                        attempt_n = retry ? attempt + 2'd1 : attempt;
                    end
            S_COOL: if (zero) begin
                nxt   = S_DRIVE;
                idx_n = '0;
            end
            default: nxt = S_IDLE;
        endcase
        load     = nxt != state;
        load_val = nxt == S_DRIVE ? CW'(HOLD - 1) :
                   nxt == S_GAP   ? CW'(GAP - 1) :
                   nxt == S_WAIT  ? CW'(TIMEOUT - 1) :
                   nxt == S_COOL  ? CW'(COOL - 1) : '0;
    end

    sender_timer #(.W(CW)) u_timer (
        .clock   (clock),
        .rst     (rst),
        .load    (load),
        .load_val(load_val),
        .zero    (zero)
    );

    always_ff @(posedge clock or negedge rst)
        if (!rst) begin
            state           <= S_IDLE;
            code_q          <= '0;
            idx             <= '0;
            attempt         <= '0;
            enable          <= '0;
            enteredPassword <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            fail            <= 1'b0;
        end else begin
            state           <= nxt;
            code_q          <= code_n;
            idx             <= idx_n;
            attempt         <= attempt_n;
            enable          <= nxt == S_DRIVE ? NUM_DIGITS'(1) << idx_n : '0;
            enteredPassword <= (nxt == S_DRIVE || nxt == S_GAP) ? digit(code_n, idx_n) : '0;
            busy            <= nxt != S_IDLE;
            done            <= nxt == S_DONE;
            fail            <= nxt == S_FAIL;
        end

endmodule

// File: tb/tb_password_sender.sv
// tb_password_sender: directed and randomized sequences checked cycle by cycle against a timeline model.
module tb_password_sender;

    localparam int HOLD = 2, GAP = 2, TIMEOUT = 16, COOL = 16, RETRIES = 3;

    logic        clock = 1'b0, rst = 1'b0, start = 1'b0, admitted = 1'b0;
    logic [15:0] code = '0;
    logic [3:0]  enable, entered_password;
    logic        busy, done, fail;
    logic [1:0]  attempt;
    int          n_assert = 0, n_fail = 0;

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] pw;
        logic       busy;
        logic [1:0] att;
        logic       done;
        logic       fail;
    } obs_t;

    typedef struct {
        obs_t o;
        logic adm;
        logic wait_c;
    } step_t;

    step_t q[$];

    always #5 clock = ~clock;

    password_sender #(.HOLD(HOLD), .GAP(GAP), .TIMEOUT(TIMEOUT), .COOL(COOL), .RETRIES(RETRIES)) dut (
        .clock          (clock),
        .rst            (rst),
        .start          (start),
        .code           (code),
        .admitted       (admitted),
        .enable         (enable),
        .enteredPassword(entered_password),
        .busy           (busy),
        .done           (done),
        .fail           (fail),
        .attempt        (attempt)
    );

    function automatic obs_t mk(input logic [3:0] en, pw, input logic b, input int att, input logic d, f);
        obs_t o;
        o.en = en; o.pw = pw; o.busy = b; o.att = 2'(att); o.done = d; o.fail = f;
        return o;
    endfunction

    task automatic push(input obs_t o, input logic adm, input logic w);
        step_t s;
        s.o = o; s.adm = adm; s.wait_c = w;
        q.push_back(s);
    endtask

    task automatic check(input string tag, input int cyc, input obs_t exp);
        obs_t o;
        o = {enable, entered_password, busy, attempt, done, fail};
        n_assert++;
        assert (o === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, exp);
        end
    endtask

    // Expected timeline from the start edge; adm[a] is the 1-based WAIT cycle carrying admitted (0 = never).
    task automatic build(input logic [15:0] c, input int adm0, adm1, adm2);
        int adm[3];
        logic [3:0] dg;
        int nw;
        adm = '{adm0, adm1, adm2};
        q.delete();
        for (int a = 0; a < RETRIES; a++) begin
            for (int d = 0; d < 4; d++) begin
                dg = c[4*d +: 4];
                for (int h = 0; h < HOLD; h++) push(mk(4'(1 << d), dg, 1, a, 0, 0), 0, 0);
                for (int g = 0; g < GAP; g++) push(mk(4'h0, dg, 1, a, 0, 0), 0, 0);
            end
            nw = adm[a] == 0 ? TIMEOUT : adm[a];
            for (int j = 1; j <= nw; j++) push(mk(4'h0, 4'h0, 1, a, 0, 0), j == adm[a], 1);
            if (adm[a] != 0) begin
                push(mk(4'h0, 4'h0, 1, a, 1, 0), 0, 0);
                for (int k = 0; k < 3; k++) push(mk(4'h0, 4'h0, 0, a, 0, 0), 0, 0);
                return;
            end
            if (a < RETRIES - 1)
                for (int k = 0; k < COOL; k++) push(mk(4'h0, 4'h0, 1, a + 1, 0, 0), 0, 0);
            else begin
                push(mk(4'h0, 4'h0, 1, a, 0, 1), 0, 0);
                for (int k = 0; k < 3; k++) push(mk(4'h0, 4'h0, 0, a, 0, 0), 0, 0);
            end
        end
    endtask

    task automatic run(input string tag, input logic [15:0] c, input int a0, a1, a2, input int stop_at);
        obs_t z;
        z = '0;
        build(c, a0, a1, a2);
        @(negedge clock);
        start = 1'b1; code = c; admitted = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < q.size(); i++) begin
            if (i == stop_at) begin
                rst = 1'b0;
                #1;
                check({tag, "_rst_now"}, i, z);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clock);
                    check({tag, "_rst_hold"}, k, z);
                end
                rst = 1'b1; start = 1'b0;
                for (int k = 0; k < 6; k++) begin
                    admitted = 1'($urandom);
                    @(negedge clock);
                    check({tag, "_post_rst"}, k, z);
                end
                admitted = 1'b0;
                return;
            end
            admitted = q[i].wait_c ? q[i].adm : 1'($urandom);
            start    = q[i].o.busy ? 1'($urandom) : 1'b0;
            code     = 16'h9999;
            @(negedge clock);
            check(tag, i, q[i].o);
            @(posedge clock);
            #1;
        end
        start = 1'b0; admitted = 1'b0;
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] c;
        for (int d = 0; d < 4; d++) c[4*d +: 4] = 4'($urandom_range(0, 9));
        return c;
    endfunction

    initial begin
        obs_t z;
        z = '0;
        #12;
        check("reset", 0, z);
        @(negedge clock);
        rst = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_after_reset", 0, z);
        run("success", 16'h4321, 3, 0, 0, -1);
        run("fail_all", 16'h4321, 0, 0, 0, -1);
        run("second_try", 16'h4321, 0, 5, 0, -1);
        run("last_wait_cycle", 16'h4321, TIMEOUT, 0, 0, -1);
        run("final_attempt_edge", 16'h0987, 0, 0, TIMEOUT, -1);
        run("reset_gap2", 16'h4321, 0, 0, 0, 4*(HOLD+GAP) + TIMEOUT + COOL + 2*(HOLD+GAP) + HOLD);
        run("after_reset", 16'h5678, 1, 0, 0, -1);
        for (int r = 0; r < 5; r++)
            run("random", rand_bcd(), $urandom_range(0, TIMEOUT), $urandom_range(0, TIMEOUT),
                $urandom_range(0, TIMEOUT), -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
